// File: rtl/icache_dm.sv
// Direct-mapped, read-only, blocking instruction cache: 256 sets x 16-byte lines.
// A miss fetches the whole line from memory, installs it, then returns the requested word.
module icache_dm (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        op,
   input  logic [7:0]  index,
   input  logic [19:0] tag,
   input  logic [3:0]  offset,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        rd_req,
   output logic [2:0]  rd_type,
   output logic [31:0] rd_addr,
   input  logic        rd_rdy,
   input  logic        ret_valid,
   input  logic        ret_last,
   input  logic [31:0] ret_data
);
   // state    | meaning
   // S_IDLE   | no request outstanding, accepting
   // S_LOOKUP | tag compare; hits and writes answer here
   // S_MISS   | line request held on the memory port
   // S_REFILL | collecting refill words into the line buffer
   // S_RESP   | returning the word captured during refill
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_RESP} state_t;

   state_t       state, state_nxt;
   logic         req_op;
   logic [7:0]   req_index;
   logic [19:0]  req_tag;
   logic [3:0]   req_offset;
   logic [255:0] valid_arr;
   logic [19:0]  tag_arr  [256];
   logic [127:0] data_arr [256];
   logic [31:0]  line_buf [4];
   logic [1:0]   cnt;
   logic [31:0]  resp_word;
   logic [127:0] hit_line;
   logic [127:0] line_next;
   logic         accept, hit, refill_beat, refill_done;
   logic         unused_bits;

   assign unused_bits = ^{wstrb, wdata, req_offset[1:0]};
   assign accept      = valid && addr_ok;
   assign hit_line    = data_arr[req_index];
   assign hit         = valid_arr[req_index] && (tag_arr[req_index] == req_tag);
   assign refill_beat = (state == S_REFILL) && ret_valid;
   assign refill_done = refill_beat && ret_last;
   assign rd_type     = 3'b100;
   assign rd_req      = (state == S_MISS);
   assign rd_addr     = rd_req ? {req_tag, req_index, 4'b0000} : 32'h0;

   // the final beat goes straight into the array alongside the buffered words
   always_comb begin
      line_next = {line_buf[3], line_buf[2], line_buf[1], line_buf[0]};
      line_next[{cnt, 5'b00000} +: 32] = ret_data;
   end

   always_comb begin
      state_nxt = state;
      addr_ok   = 1'b0;
      data_ok   = 1'b0;
      rdata     = 32'h0;
      case (state)
         S_IDLE: begin
            addr_ok = 1'b1;
            if (valid) state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (req_op || hit) begin
               data_ok   = 1'b1;
               addr_ok   = 1'b1;
               rdata     = req_op ? 32'h0 : hit_line[{req_offset[3:2], 5'b00000} +: 32];
               state_nxt = valid ? S_LOOKUP : S_IDLE;
            end else begin
               state_nxt = S_MISS;
            end
         end
         S_MISS:   if (rd_rdy) state_nxt = S_REFILL;
         S_REFILL: if (refill_done) state_nxt = S_RESP;
         S_RESP: begin
            data_ok   = 1'b1;
            rdata     = resp_word;
            state_nxt = S_IDLE;
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         req_op     <= 1'b0;
         req_index  <= 8'h0;
         req_tag    <= 20'h0;
         req_offset <= 4'h0;
         valid_arr  <= '0;
         cnt        <= 2'd0;
         resp_word  <= 32'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            req_op     <= op;
            req_index  <= index;
            req_tag    <= tag;
            req_offset <= offset;
         end
         if (state == S_MISS && rd_rdy) cnt <= 2'd0;
         else if (refill_beat)          cnt <= cnt + 2'd1;
         if (refill_beat && cnt == req_offset[3:2]) resp_word <= ret_data;
         if (refill_done) valid_arr[req_index] <= 1'b1;
      end
   end

   // storage arrays carry no reset; the valid bits alone qualify them
   always_ff @(posedge clk) begin
      if (refill_beat) line_buf[cnt] <= ret_data;
      if (refill_done) begin
         data_arr[req_index] <= line_next;
         tag_arr[req_index]  <= req_tag;
      end
   end
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: misses, hit streaming, conflicts, delayed rd_rdy,
// dropped writes and reset during refill, all against hand-computed values.
module tb_icache_dm;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid, op;
   logic [7:0]  index;
   logic [19:0] tag;
   logic [3:0]  offset, wstrb;
   logic [31:0] wdata;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;
   logic        rd_req;
   logic [2:0]  rd_type;
   logic [31:0] rd_addr;
   logic        rd_rdy, ret_valid, ret_last;
   logic [31:0] ret_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   icache_dm dut (
      .clk(clk), .reset(reset), .valid(valid), .op(op), .index(index), .tag(tag),
      .offset(offset), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok),
      .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type),
      .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
      .ret_last(ret_last), .ret_data(ret_data)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic o, input logic [7:0] i, input logic [19:0] t,
                            input logic [3:0] f);
      valid = 1'b1; op = o; index = i; tag = t; offset = f;
   endtask

   task automatic read_hit(input logic [7:0] i, input logic [19:0] t, input logic [3:0] f,
                           input logic [31:0] exp);
      drive_req(1'b0, i, t, f);
      cyc();
      valid = 1'b0;
      @(negedge clk);
      check("hit_data_ok", {31'b0, data_ok}, 32'd1);
      check("hit_rdata", rdata, exp);
      check("hit_rd_req", {31'b0, rd_req}, 32'd0);
      cyc();
   endtask

   task automatic read_miss(input logic [7:0] i, input logic [19:0] t, input logic [3:0] f,
                            input logic [127:0] line, input int delay, input logic [31:0] exp);
      logic [31:0] exp_addr;
      exp_addr = {t, i, 4'h0};
      drive_req(1'b0, i, t, f);
      cyc();
      valid = 1'b0;
      @(negedge clk);
      check("lookup_addr_ok", {31'b0, addr_ok}, 32'd0);
      check("lookup_data_ok", {31'b0, data_ok}, 32'd0);
      cyc();
      for (int k = 0; k < delay; k++) begin
         @(negedge clk);
         check("wait_rd_req", {31'b0, rd_req}, 32'd1);
         check("wait_rd_addr", rd_addr, exp_addr);
         check("wait_addr_ok", {31'b0, addr_ok}, 32'd0);
         check("wait_data_ok", {31'b0, data_ok}, 32'd0);
         cyc();
      end
      rd_rdy = 1'b1;
      @(negedge clk);
      check("miss_rd_req", {31'b0, rd_req}, 32'd1);
      check("miss_rd_addr", rd_addr, exp_addr);
      check("miss_rd_type", {29'b0, rd_type}, 32'd4);
      cyc();
      rd_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ret_valid = 1'b1;
         ret_data  = line[32*k +: 32];
         ret_last  = (k == 3);
         @(negedge clk);
         check("refill_data_ok", {31'b0, data_ok}, 32'd0);
         cyc();
      end
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      @(negedge clk);
      check("resp_data_ok", {31'b0, data_ok}, 32'd1);
      check("resp_rdata", rdata, exp);
      check("resp_addr_ok", {31'b0, addr_ok}, 32'd0);
      cyc();
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; op = 1'b0; index = '0; tag = '0; offset = '0;
      wstrb = '0; wdata = '0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
      ret_data = '0;
      cyc();
      cyc();
      @(negedge clk);
      check("rst_addr_ok", {31'b0, addr_ok}, 32'd1);
      check("rst_data_ok", {31'b0, data_ok}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_rd_req", {31'b0, rd_req}, 32'd0);
      check("rst_rd_addr", rd_addr, 32'h0);
      check("rst_rd_type", {29'b0, rd_type}, 32'd4);
      reset = 1'b0;
      cyc();

      // cold miss, word 1 of 0x11/0x22/0x33/0x44
      read_miss(8'h00, 20'hBFC00, 4'h4, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 32'h22);

      // back-to-back hits, one word per cycle
      drive_req(1'b0, 8'h00, 20'hBFC00, 4'h0);
      cyc();
      offset = 4'h8;
      @(negedge clk);
      check("stream0_data_ok", {31'b0, data_ok}, 32'd1);
      check("stream0_rdata", rdata, 32'h11);
      check("stream0_addr_ok", {31'b0, addr_ok}, 32'd1);
      cyc();
      offset = 4'hC;
      @(negedge clk);
      check("stream1_data_ok", {31'b0, data_ok}, 32'd1);
      check("stream1_rdata", rdata, 32'h33);
      check("stream1_addr_ok", {31'b0, addr_ok}, 32'd1);
      cyc();
      valid = 1'b0;
      @(negedge clk);
      check("stream2_data_ok", {31'b0, data_ok}, 32'd1);
      check("stream2_rdata", rdata, 32'h44);
      check("stream2_rd_req", {31'b0, rd_req}, 32'd0);
      cyc();
      @(negedge clk);
      check("stream_idle_data_ok", {31'b0, data_ok}, 32'd0);

      // dropped write, then original word still there
      drive_req(1'b1, 8'h00, 20'hBFC00, 4'h4);
      wstrb = 4'hF; wdata = 32'hDEADBEEF;
      cyc();
      valid = 1'b0; op = 1'b0;
      @(negedge clk);
      check("wr_data_ok", {31'b0, data_ok}, 32'd1);
      check("wr_rdata", rdata, 32'h0);
      check("wr_rd_req", {31'b0, rd_req}, 32'd0);
      cyc();
      read_hit(8'h00, 20'hBFC00, 4'h4, 32'h22);

      // conflict miss with 5-cycle rd_rdy delay replaces the resident line
      read_miss(8'h00, 20'h00001, 4'hC, {32'h88, 32'h77, 32'h66, 32'h55}, 5, 32'h88);
      read_hit(8'h00, 20'h00001, 4'h0, 32'h55);
      read_hit(8'h00, 20'h00001, 4'h4, 32'h66);
      read_miss(8'h00, 20'hBFC00, 4'h8, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 32'h33);

      // reset after two refill words
      drive_req(1'b0, 8'h05, 20'h12345, 4'h0);
      cyc();
      valid = 1'b0;
      cyc();
      rd_rdy = 1'b1;
      cyc();
      rd_rdy = 1'b0;
      ret_valid = 1'b1; ret_data = 32'hA1;
      cyc();
      ret_data = 32'hA2;
      cyc();
      ret_data = 32'hA3;
      reset = 1'b1;
      #1;
      check("mid_rst_addr_ok", {31'b0, addr_ok}, 32'd1);
      check("mid_rst_data_ok", {31'b0, data_ok}, 32'd0);
      check("mid_rst_rd_req", {31'b0, rd_req}, 32'd0);
      check("mid_rst_rd_addr", rd_addr, 32'h0);
      check("mid_rst_rdata", rdata, 32'h0);
      ret_last = 1'b1;
      cyc();
      reset = 1'b0;
      ret_data = 32'hA4;
      cyc();
      ret_valid = 1'b0; ret_last = 1'b0;
      @(negedge clk);
      check("stray_beat_data_ok", {31'b0, data_ok}, 32'd0);
      cyc();
      read_miss(8'h05, 20'h12345, 4'h0, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 0, 32'hB1);
      read_hit(8'h05, 20'h12345, 4'hC, 32'hB4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
